// File: rtl/instr_queue.sv
// instr_queue: decoupling FIFO between the fetcher and decode.
// Stores {pc, instr} pairs in a circular buffer, presents the head entry
// with a valid/ready handshake, flushes on redirect and throttles the
// fetcher through fetch_en so in-flight fetches always find space.
module instr_queue #(
  parameter int bits  = 32,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [bits-1:0]          push_pc,
  input  logic [bits-1:0]          push_instr,
  output logic                     push_ready,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [bits-1:0]          pop_pc,
  output logic [bits-1:0]          pop_instr,
  input  logic                     flush,
  output logic                     fetch_en,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] FETCH_LIM = CW'(DEPTH - SLACK);

  logic [bits-1:0] pc_mem_q    [DEPTH];
  logic [bits-1:0] instr_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          do_push,  do_pop;

  // Handshake and status outputs derived purely from registered state.
  always_comb begin
    push_ready = (count_q != FULL_CNT);
    pop_valid  = (count_q != '0);
    fetch_en   = (count_q < FETCH_LIM);
    count      = count_q;
    do_push    = push_valid & push_ready & ~flush;
    do_pop     = pop_valid & pop_ready & ~flush;
    pop_pc     = pop_valid ? pc_mem_q[rd_ptr_q]    : '0;
    pop_instr  = pop_valid ? instr_mem_q[rd_ptr_q] : '0;
  end

  // Next pointer/count: flush wins, otherwise independent push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed scenarios plus random traffic for instr_queue,
// checked every cycle against a queue-based reference model.
module tb_instr_queue;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int SLACK = 1;

  logic              clk;
  logic              rst;
  logic              push_valid;
  logic [BITS-1:0]   push_pc;
  logic [BITS-1:0]   push_instr;
  logic              push_ready;
  logic              pop_valid;
  logic              pop_ready;
  logic [BITS-1:0]   pop_pc;
  logic [BITS-1:0]   pop_instr;
  logic              flush;
  logic              fetch_en;
  logic [$clog2(DEPTH):0] count;

  instr_queue #(.bits(BITS), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_pc(pop_pc), .pop_instr(pop_instr),
    .flush(flush), .fetch_en(fetch_en), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of entries.
  typedef struct { logic [BITS-1:0] pc; logic [BITS-1:0] instr; } entry_t;
  entry_t mq[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit mpush, mpop;
      entry_t e;
      mpush = push_valid && (mq.size() != DEPTH) && !flush;
      mpop  = pop_ready && (mq.size() != 0) && !flush;
      if (flush) mq.delete();
      else begin
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
          e.pc = push_pc; e.instr = push_instr;
          mq.push_back(e);
        end
      end
    end
  end

  // Log of PCs actually handed to decode by the DUT.
  logic [BITS-1:0] plog[$];
  always @(posedge clk) begin
    if (rst && pop_valid && pop_ready && !flush) plog.push_back(pop_pc);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("count",      count,      n);
      chk("pop_valid",  pop_valid,  n != 0);
      chk("push_ready", push_ready, n != DEPTH);
      chk("fetch_en",   fetch_en,   (DEPTH - n) > SLACK);
      chk("pop_pc",     pop_pc,     (n != 0) ? mq[0].pc : '0);
      chk("pop_instr",  pop_instr,  (n != 0) ? mq[0].instr : '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [BITS-1:0] pc);
    push_valid = 1'b1;
    push_pc    = pc;
    push_instr = pc ^ 32'h0000_0013;
    step();
  endtask

  task automatic idle();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic chk_log(input string name, input logic [BITS-1:0] exp[$]);
    chk({name, "_len"}, plog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < plog.size(); i++)
      chk(name, plog[i], exp[i]);
  endtask

  initial begin
    logic [BITS-1:0] exp[$];
    rst = 1'b0;
    push_pc = '0; push_instr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_fetch_en", fetch_en, 1);
    chk("rst_pop_pc", pop_pc, 0);
    chk("rst_pop_instr", pop_instr, 0);
    chk_en = 1;
    step();

    // Basic in-order delivery.
    push_one(32'h0);
    push_one(32'h4);
    push_one(32'h8);
    push_valid = 1'b0;
    chk("basic_count3", count, 3);
    chk("basic_head", pop_pc, 32'h0);
    chk("basic_head_instr", pop_instr, 32'h13);
    chk("basic_fetch_en", fetch_en, 0);
    plog.delete();
    pop_ready = 1'b1;
    step(); chk("basic_count2", count, 2);
    step(); chk("basic_count1", count, 1);
    step(); chk("basic_count0", count, 0);
    chk("basic_empty", pop_valid, 0);
    exp = '{32'h0, 32'h4, 32'h8};
    chk_log("basic_order", exp);
    idle(); step();

    // Fill to capacity; the fifth push is dropped.
    push_one(32'h0);
    push_one(32'h4);
    push_one(32'h8);
    chk("full_fetch_en3", fetch_en, 0);
    chk("full_ready3", push_ready, 1);
    push_one(32'hC);
    chk("full_count4", count, 4);
    chk("full_ready4", push_ready, 0);
    push_one(32'h10);
    push_valid = 1'b0;
    chk("full_count_after5", count, 4);
    plog.delete();
    pop_ready = 1'b1;
    repeat (6) step();
    exp = '{32'h0, 32'h4, 32'h8, 32'hC};
    chk_log("full_order", exp);
    idle(); step();

    // Streaming push+pop at count=2 across pointer wrap.
    push_one(32'h100);
    push_one(32'h104);
    plog.delete();
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(32'h108 + 4 * i);
      chk("stream_count", count, 2);
    end
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(32'h100 + 4 * i);
    chk_log("stream_order", exp);
    push_valid = 1'b0;
    repeat (3) step();
    idle(); step();

    // Flush beats simultaneous push and pop.
    push_one(32'h1A0);
    push_one(32'h1A4);
    push_one(32'h1A8);
    chk("flush_pre_count", count, 3);
    plog.delete();
    flush = 1'b1; push_valid = 1'b1; push_pc = 32'h200; push_instr = 32'hDEAD;
    pop_ready = 1'b1;
    step();
    idle();
    chk("flush_count", count, 0);
    chk("flush_pop_valid", pop_valid, 0);
    chk("flush_fetch_en", fetch_en, 1);
    push_one(32'h300);
    push_valid = 1'b0;
    pop_ready = 1'b1;
    repeat (2) step();
    exp = '{32'h300};
    chk_log("flush_order", exp);
    idle(); step();

    // Asynchronous reset between edges.
    push_one(32'h400);
    push_one(32'h404);
    push_valid = 1'b0;
    chk("areset_pre_count", count, 2);
    chk_en = 0;
    #2 rst = 1'b0;
    #1;
    chk("areset_count", count, 0);
    chk("areset_pop_valid", pop_valid, 0);
    chk("areset_push_ready", push_ready, 1);
    chk("areset_fetch_en", fetch_en, 1);
    chk("areset_pop_pc", pop_pc, 0);
    chk_en = 1;
    step();
    rst = 1'b1;
    plog.delete();
    pop_ready = 1'b1;
    repeat (3) step();
    chk("areset_no_stale", plog.size(), 0);
    idle(); step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_pc    = $urandom;
      push_instr = $urandom;
      pop_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      step();
    end
    idle();
    repeat (2) step();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
